// File: rtl/cv32e40s_clic_arbiter.sv
// CLIC arbitration stage: per-interrupt configuration and pending state, level/ID
// arbitration and a registered interrupt request towards the core.
module cv32e40s_clic_arbiter #(
    parameter int NUM_INTERRUPTS  = 32,
    parameter int SMCLIC_ID_WIDTH = 5,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_INTERRUPTS-1:0]  irq_src_i,
    input  logic                       cfg_we_i,
    input  logic [SMCLIC_ID_WIDTH-1:0] cfg_id_i,
    input  logic                       cfg_ie_i,
    input  logic                       cfg_trig_i,
    input  logic [7:0]                 cfg_level_i,
    input  logic                       cfg_shv_i,
    input  logic                       sw_set_i,
    input  logic                       irq_ack_i,
    input  logic [SMCLIC_ID_WIDTH-1:0] irq_ack_id_i,
    output logic                       clic_irq_o,
    output logic [SMCLIC_ID_WIDTH-1:0] clic_irq_id_o,
    output logic [7:0]                 clic_irq_level_o,
    output logic [1:0]                 clic_irq_priv_o,
    output logic                       clic_irq_shv_o
);

    localparam logic ST_ARB   = 1'b0;
    localparam logic ST_BLANK = 1'b1;

    logic                          state_q;
    logic [NUM_INTERRUPTS-1:0]     src_s;
    logic [NUM_INTERRUPTS-1:0]     src_prev_q;
    logic [NUM_INTERRUPTS-1:0]     ie_q;
    logic [NUM_INTERRUPTS-1:0]     trig_q;
    logic [NUM_INTERRUPTS-1:0]     shv_q;
    logic [NUM_INTERRUPTS-1:0]     edge_pend_q;
    logic [7:0]                    level_q [NUM_INTERRUPTS];

    logic [NUM_INTERRUPTS-1:0]     wr_hit;
    logic [NUM_INTERRUPTS-1:0]     ack_hit;
    logic [NUM_INTERRUPTS-1:0]     sw_hit;
    logic [NUM_INTERRUPTS-1:0]     level_nz;
    logic [NUM_INTERRUPTS-1:0]     trig_chg;
    logic [NUM_INTERRUPTS-1:0]     edge_set;
    logic [NUM_INTERRUPTS-1:0]     pending;
    logic [NUM_INTERRUPTS-1:0]     cand;

    logic                          best_found;
    logic [SMCLIC_ID_WIDTH-1:0]    best_id;
    logic [7:0]                    best_level;
    logic                          best_shv;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign src_s = irq_src_i;
        end else begin : g_sync
            logic [NUM_INTERRUPTS-1:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
                end else begin
                    sync_q[0] <= irq_src_i;
                    for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
                end
            end
            assign src_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // IDs at or above NUM_INTERRUPTS never match any entry, so such writes/acks are dropped.
    always_comb begin
        wr_hit   = '0;
        ack_hit  = '0;
        sw_hit   = '0;
        level_nz = '0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            wr_hit[i]   = cfg_we_i  && (cfg_id_i     == SMCLIC_ID_WIDTH'(i));
            ack_hit[i]  = irq_ack_i && (irq_ack_id_i == SMCLIC_ID_WIDTH'(i));
            sw_hit[i]   = sw_set_i  && (cfg_id_i     == SMCLIC_ID_WIDTH'(i));
            level_nz[i] = (level_q[i] != 8'd0);
        end
    end

    assign trig_chg = wr_hit & (trig_q ^ {NUM_INTERRUPTS{cfg_trig_i}});
    assign edge_set = trig_q & ((src_s & ~src_prev_q) | sw_hit);
    assign pending  = (trig_q & edge_pend_q) | (~trig_q & src_s);
    assign cand     = pending & ie_q & level_nz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_q  <= '0;
            edge_pend_q <= '0;
            ie_q        <= '0;
            trig_q      <= '0;
            shv_q       <= '0;
            for (int i = 0; i < NUM_INTERRUPTS; i++) level_q[i] <= 8'd0;
        end else begin
            src_prev_q  <= src_s;
            // Set beats ack-clear; a trigger-mode change always drops the stale edge bit.
            edge_pend_q <= (edge_set | (edge_pend_q & ~ack_hit)) & ~trig_chg;
            for (int i = 0; i < NUM_INTERRUPTS; i++) begin
                if (wr_hit[i]) begin
                    ie_q[i]    <= cfg_ie_i;
                    trig_q[i]  <= cfg_trig_i;
                    shv_q[i]   <= cfg_shv_i;
                    level_q[i] <= cfg_level_i;
                end
            end
        end
    end

    // Ascending scan with >= lets the highest ID win among equal levels.
    always_comb begin
        best_found = 1'b0;
        best_id    = '0;
        best_level = 8'd0;
        best_shv   = 1'b0;
        for (int i = 0; i < NUM_INTERRUPTS; i++) begin
            if (cand[i] && (level_q[i] >= best_level)) begin
                best_found = 1'b1;
                best_id    = SMCLIC_ID_WIDTH'(i);
                best_level = level_q[i];
                best_shv   = shv_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_ARB;
            clic_irq_o       <= 1'b0;
            clic_irq_id_o    <= '0;
            clic_irq_level_o <= 8'd0;
            clic_irq_shv_o   <= 1'b0;
        end else if (state_q == ST_ARB && irq_ack_i) begin
            state_q    <= ST_BLANK;
            clic_irq_o <= 1'b0;
        end else begin
            state_q    <= ST_ARB;
            clic_irq_o <= best_found;
            if (best_found) begin
                clic_irq_id_o    <= best_id;
                clic_irq_level_o <= best_level;
                clic_irq_shv_o   <= best_shv;
            end
        end
    end

    assign clic_irq_priv_o = 2'b11;

endmodule

// File: tb/tb_cv32e40s_clic_arbiter.sv
// Directed plus randomized bench for cv32e40s_clic_arbiter; a cycle-level reference
// model queues expected outputs that a separate monitor compares after every edge.
module tb_cv32e40s_clic_arbiter;

    localparam int N  = 24;
    localparam int IW = 5;
    localparam int SS = 2;

    typedef struct packed {
        logic          irq;
        logic [IW-1:0] id;
        logic [7:0]    level;
        logic [1:0]    priv;
        logic          shv;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_id = '0;
    logic          cfg_ie = 1'b0;
    logic          cfg_trig = 1'b0;
    logic [7:0]    cfg_level = 8'd0;
    logic          cfg_shv = 1'b0;
    logic          sw_set = 1'b0;
    logic          irq_ack = 1'b0;
    logic [IW-1:0] irq_ack_id = '0;

    logic          clic_irq;
    logic [IW-1:0] clic_irq_id;
    logic [7:0]    clic_irq_level;
    logic [1:0]    clic_irq_priv;
    logic          clic_irq_shv;
    out_t          act;

    out_t expQ[$];
    int   checks = 0;
    int   passes = 0;

    bit [N-1:0] mHist[$];
    bit [N-1:0] mPrev;
    bit         mIe   [N];
    bit         mTrig [N];
    bit         mShv  [N];
    bit         mPend [N];
    bit [7:0]   mLvl  [N];
    bit         mJustAcked;
    out_t       mOut;

    cv32e40s_clic_arbiter #(
        .NUM_INTERRUPTS (N),
        .SMCLIC_ID_WIDTH(IW),
        .SYNC_STAGES    (SS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_src_i       (irq_src),
        .cfg_we_i        (cfg_we),
        .cfg_id_i        (cfg_id),
        .cfg_ie_i        (cfg_ie),
        .cfg_trig_i      (cfg_trig),
        .cfg_level_i     (cfg_level),
        .cfg_shv_i       (cfg_shv),
        .sw_set_i        (sw_set),
        .irq_ack_i       (irq_ack),
        .irq_ack_id_i    (irq_ack_id),
        .clic_irq_o      (clic_irq),
        .clic_irq_id_o   (clic_irq_id),
        .clic_irq_level_o(clic_irq_level),
        .clic_irq_priv_o (clic_irq_priv),
        .clic_irq_shv_o  (clic_irq_shv)
    );

    assign act = {clic_irq, clic_irq_id, clic_irq_level, clic_irq_priv, clic_irq_shv};

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input out_t a, input out_t e);
        checks++;
        if (a === e) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s @%0t: got irq=%0b id=%0d level=%02h priv=%0b shv=%0b, expected irq=%0b id=%0d level=%02h priv=%0b shv=%0b",
                     name, $time, a.irq, a.id, a.level, a.priv, a.shv, e.irq, e.id, e.level, e.priv, e.shv);
        end
    endtask

    task automatic modelReset();
        mHist.delete();
        for (int s = 0; s < SS; s++) mHist.push_back('0);
        mPrev = '0;
        for (int i = 0; i < N; i++) begin
            mIe[i] = 0; mTrig[i] = 0; mShv[i] = 0; mPend[i] = 0; mLvl[i] = 8'd0;
        end
        mJustAcked = 0;
        mOut = '{irq: 1'b0, id: '0, level: 8'd0, priv: 2'b11, shv: 1'b0};
    endtask

    // One clock of the reference model, using the inputs about to be sampled.
    task automatic modelStep();
        bit [N-1:0] srcS;
        int bestKey;
        int key;
        bit pend;
        bit setIt;
        if (!rst_n) begin
            modelReset();
        end else begin
            srcS = (SS == 0) ? irq_src : mHist[0];
            bestKey = -1;
            for (int i = 0; i < N; i++) begin
                pend = mTrig[i] ? mPend[i] : srcS[i];
                if (pend && mIe[i] && mLvl[i] != 0) begin
                    key = int'(mLvl[i]) * 1024 + i;
                    if (key > bestKey) bestKey = key;
                end
            end
            if (!mJustAcked && irq_ack) begin
                mOut.irq = 1'b0;
            end else if (bestKey >= 0) begin
                mOut.irq   = 1'b1;
                mOut.id    = IW'(bestKey % 1024);
                mOut.level = 8'(bestKey / 1024);
                mOut.shv   = mShv[bestKey % 1024];
            end else begin
                mOut.irq = 1'b0;
            end
            mJustAcked = !mJustAcked && irq_ack;
            for (int i = 0; i < N; i++) begin
                if (mTrig[i]) begin
                    setIt = (srcS[i] && !mPrev[i]) || (sw_set && int'(cfg_id) == i);
                    if (setIt) mPend[i] = 1;
                    else if (irq_ack && int'(irq_ack_id) == i) mPend[i] = 0;
                end
                if (cfg_we && int'(cfg_id) == i && cfg_trig != mTrig[i]) mPend[i] = 0;
            end
            if (cfg_we && int'(cfg_id) < N) begin
                mIe[cfg_id] = cfg_ie; mTrig[cfg_id] = cfg_trig;
                mLvl[cfg_id] = cfg_level; mShv[cfg_id] = cfg_shv;
            end
            mPrev = srcS;
            if (SS > 0) begin
                mHist.push_back(irq_src);
                void'(mHist.pop_front());
            end
        end
        expQ.push_back(mOut);
    endtask

    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        cfg_we  = 1'b0;
        sw_set  = 1'b0;
        irq_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus();
    endtask

    task automatic cfgWrite(input int id, input bit ie, input bit trig, input bit [7:0] lvl, input bit shv);
        cfg_we = 1'b1; cfg_id = IW'(id); cfg_ie = ie; cfg_trig = trig; cfg_level = lvl; cfg_shv = shv;
        applyStimulus();
    endtask

    task automatic swSet(input int id);
        sw_set = 1'b1; cfg_id = IW'(id);
        applyStimulus();
    endtask

    task automatic ackIrq(input int id);
        irq_ack = 1'b1; irq_ack_id = IW'(id);
        applyStimulus();
    endtask

    initial begin : monitor
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cycle", act, e);
            end
        end
    end

    initial begin : driver
        modelReset();
        #1;
        checkOutput("reset_state", act, '{irq: 1'b0, id: '0, level: 8'd0, priv: 2'b11, shv: 1'b0});
        @(negedge clk);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        $display("[TB] level-triggered ID 3");
        cfgWrite(3, 1, 0, 8'h40, 0);
        irq_src[3] = 1'b1; idle(4);
        irq_src[3] = 1'b0; idle(4);

        $display("[TB] edge IDs 5 and 9, ack 9");
        cfgWrite(5, 1, 1, 8'h20, 0);
        cfgWrite(9, 1, 1, 8'h80, 1);
        irq_src[5] = 1'b1; irq_src[9] = 1'b1; idle(1);
        irq_src[5] = 1'b0; irq_src[9] = 1'b0; idle(4);
        ackIrq(9); idle(3);
        ackIrq(5); idle(2);

        $display("[TB] tie between IDs 2 and 7");
        cfgWrite(2, 1, 1, 8'h55, 0);
        cfgWrite(7, 1, 1, 8'h55, 1);
        irq_src[2] = 1'b1; irq_src[7] = 1'b1; idle(1);
        irq_src[2] = 1'b0; irq_src[7] = 1'b0; idle(4);
        ackIrq(7); idle(2);
        ackIrq(2); idle(2);

        $display("[TB] edge coinciding with ack on ID 4");
        cfgWrite(4, 1, 1, 8'h30, 0);
        irq_src[4] = 1'b1; idle(1);
        irq_src[4] = 1'b0; idle(4);
        irq_src[4] = 1'b1; idle(2);
        ackIrq(4);
        irq_src[4] = 1'b0; idle(3);
        ackIrq(4); idle(2);

        $display("[TB] masked entries, sw_set, out-of-range IDs");
        cfgWrite(11, 1, 0, 8'h00, 0);
        irq_src[11] = 1'b1; idle(4);
        cfgWrite(11, 1, 0, 8'h10, 0); idle(2);
        irq_src[11] = 1'b0; idle(3);
        cfgWrite(12, 0, 1, 8'h60, 0);
        swSet(12); idle(2);
        cfgWrite(12, 1, 1, 8'h60, 0); idle(2);
        cfgWrite(13, 1, 1, 8'h70, 1);
        swSet(13); idle(2);
        ackIrq(13); idle(2);
        ackIrq(12); idle(2);
        cfgWrite(30, 1, 0, 8'hff, 1);
        ackIrq(31); idle(2);

        $display("[TB] async reset while valid");
        cfgWrite(14, 1, 1, 8'h90, 0);
        irq_src[14] = 1'b1; idle(1);
        irq_src[14] = 1'b0; idle(4);
        irq_src[15] = 1'b1; idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", act, '{irq: 1'b0, id: '0, level: 8'd0, priv: 2'b11, shv: 1'b0});
        irq_src = '0;
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;
        idle(6);

        $display("[TB] randomized phase");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) irq_src[$urandom_range(0, N-1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                cfg_we = 1'b1; cfg_id = IW'($urandom_range(0, 31));
                cfg_ie = ($urandom_range(0, 4) != 0); cfg_trig = 1'($urandom_range(0, 1));
                cfg_level = 8'($urandom_range(0, 3) * 8'h40); cfg_shv = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) begin
                sw_set = 1'b1;
                if (!cfg_we) cfg_id = IW'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 5) == 0) begin
                irq_ack = 1'b1;
                irq_ack_id = ($urandom_range(0, 1) == 0) ? mOut.id : IW'($urandom_range(0, 31));
            end
            applyStimulus();
        end

        irq_src = '0;
        idle(4);
        @(posedge clk);
        #2;
        checks++;
        if (expQ.size() == 0) passes++;
        else $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
